// File: rtl/dmem_responder_pkg.sv
// Shared types and RISC-V width codes for the data-memory responder.
// Also holds the request legality check used at acceptance time.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width/alignment legality only; the address range check lives in the top.
    function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (f3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = lo[0];
                F3_W:    bad = (lo != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = lo[0];
                F3_W:        bad = (lo != 2'b00);
                default:     bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and the responder.
// Both channels: a transfer happens on a rising edge where valid && ready are both high.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane steering: store byte enables and replicated lanes, load lane select
// with sign or zero extension. Purely combinational.
module mem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        case (funct3)
            F3_B: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            F3_W: begin
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wdata;
            end
        endcase
    end

    always_comb begin
        rbyte = rword[7:0];
        case (addr_lo)
            2'd0: rbyte = rword[7:0];
            2'd1: rbyte = rword[15:8];
            2'd2: rbyte = rword[23:16];
            2'd3: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

        rdata = 32'h0;
        case (funct3)
            F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata = {24'h0, rbyte};
            F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata = {16'h0, rhalf};
            F3_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a word RAM and fixed access latency.
// Request fields are captured on acceptance, so the bus may change afterwards.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic             clk,
    input  logic             nrst,
    dmem_responder_if.slave  bus,
    output state_t           fsm_state
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t state, state_nx;

    logic [2:0]       cnt;
    logic             cap_we;
    logic [2:0]       cap_funct3;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_lo;
    logic [31:0]      cap_wdata;
    logic             cap_err;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             req_err;
    logic             access;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [31:0]      load_ext;
    logic [31:0]      rword;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_err = req_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) ||
                     ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign access  = (state == ST_WAIT) && (cnt == 3'd0);
    assign rword   = mem[cap_idx];

    mem_lane_align u_align (
        .addr_lo (cap_lo),
        .funct3  (cap_funct3),
        .wdata   (cap_wdata),
        .rword   (rword),
        .be      (be),
        .wlanes  (wlanes),
        .rdata   (load_ext)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.req_valid)    state_nx = ST_WAIT;
            ST_WAIT: if (cnt == 3'd0)      state_nx = ST_RESP;
            ST_RESP: if (bus.resp_ready)   state_nx = ST_IDLE;
            default:                       state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = (state == ST_RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        fsm_state      = state;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt        <= 3'd0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_idx    <= '0;
            cap_lo     <= 2'd0;
            cap_wdata  <= 32'h0;
            cap_err    <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_we     <= bus.req_we;
                        cap_funct3 <= bus.req_funct3;
                        cap_idx    <= bus.req_addr[IDX_W+1:2];
                        cap_lo     <= bus.req_addr[1:0];
                        cap_wdata  <= bus.req_wdata;
                        cap_err    <= req_err;
                        cnt        <= 3'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata_q <= (cap_err || cap_we) ? 32'h0 : load_ext;
                        err_q   <= cap_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; a reset before the access edge leaves state IDLE so no write occurs.
    always_ff @(posedge clk) begin
        if (access && cap_we && !cap_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cap_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end
endmodule
